// File: rtl/tinygpu_pkg.sv
// Shared tinyGPU register-file constants, used by the register file, the
// control unit and the benches.
package tinygpu_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;

    // Register indices with a fixed role, independent of the opcode.
    localparam int REG_ZERO = 0;
    localparam int REG_AR   = 14;
    localparam int REG_DR   = 15;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, optional hardwired R0 and the
// same-cycle write bypass (port 0 beats port 1).
module regfile_read_port
    import tinygpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic [ADDR_W-1:0] rn_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic              wacc0_i,
    input  logic [ADDR_W-1:0] wn0_i,
    input  logic [DATA_W-1:0] d0_i,
    input  logic              wacc1_i,
    input  logic [ADDR_W-1:0] wn1_i,
    input  logic [DATA_W-1:0] d1_i,
    output logic [DATA_W-1:0] q_o
);

    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] ZERO_IDX   = ADDR_W'(REG_ZERO);

    logic rn_ok;

    assign rn_ok = ({1'b0, rn_i} < NUM_REGS_X) && !((ZERO_R0 != 0) && (rn_i == ZERO_IDX));

    // wacc*_i are already qualified as accepted writes, so a bypass never
    // forwards data that will not be stored.
    always_comb begin
        q_o = '0;
        if (rn_ok) begin
            q_o = regs_i[rn_i];
            if (BYPASS != 0) begin
                if (wacc1_i && (wn1_i == rn_i)) q_o = d1_i;
                if (wacc0_i && (wn0_i == rn_i)) q_o = d0_i;
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised tinyGPU register file: 3 read ports, 2 prioritised write ports,
// post-incrementing AR, busy scoreboard and synchronous clear.
module regfile_param
    import tinygpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int AR_IDX   = REG_AR,
    parameter int DR_IDX   = REG_DR,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   rna,
    input  logic [ADDR_W-1:0]   rnb,
    input  logic [ADDR_W-1:0]   rnc,
    output logic [DATA_W-1:0]   qa,
    output logic [DATA_W-1:0]   qb,
    output logic [DATA_W-1:0]   qc,
    input  logic                we0,
    input  logic [ADDR_W-1:0]   wn0,
    input  logic [DATA_W-1:0]   d0,
    input  logic                we1,
    input  logic [ADDR_W-1:0]   wn1,
    input  logic [DATA_W-1:0]   d1,
    input  logic                ar_inc,
    input  logic                busy_set,
    input  logic [ADDR_W-1:0]   busy_rn,
    output logic [NUM_REGS-1:0] busy,
    output logic [DATA_W-1:0]   DR,
    output logic [DATA_W-1:0]   AR
);

    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] ZERO_IDX   = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wacc0;
    logic                wacc1;
    logic                bset_ok;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} < NUM_REGS_X) && !((ZERO_R0 != 0) && (idx == ZERO_IDX));
    endfunction

    assign wacc0   = we0 && idx_ok(wn0);
    assign wacc1   = we1 && idx_ok(wn1);
    assign bset_ok = busy_set && idx_ok(busy_rn);

    // Later assignments win: increment < port 1 < port 0, and busy set beats
    // the write-clear so a newly issued producer stays pending.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (ar_inc) regs_d[AR_IDX] = regs_q[AR_IDX] + DATA_W'(1);
        if (wacc1) begin
            regs_d[wn1] = d1;
            busy_d[wn1] = 1'b0;
        end
        if (wacc0) begin
            regs_d[wn0] = d0;
            busy_d[wn0] = 1'b0;
        end
        if (bset_ok) busy_d[busy_rn] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign DR   = regs_q[DR_IDX];
    assign AR   = regs_q[AR_IDX];

    regfile_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_rd_a (
        .rn_i(rna), .regs_i(regs_q),
        .wacc0_i(wacc0), .wn0_i(wn0), .d0_i(d0),
        .wacc1_i(wacc1), .wn1_i(wn1), .d1_i(d1),
        .q_o(qa)
    );

    regfile_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_rd_b (
        .rn_i(rnb), .regs_i(regs_q),
        .wacc0_i(wacc0), .wn0_i(wn0), .d0_i(d0),
        .wacc1_i(wacc1), .wn1_i(wn1), .d1_i(d1),
        .q_o(qb)
    );

    regfile_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
    ) u_rd_c (
        .rn_i(rnc), .regs_i(regs_q),
        .wacc0_i(wacc0), .wn0_i(wn0), .d0_i(d0),
        .wacc1_i(wacc1), .wn1_i(wn1), .d1_i(d1),
        .q_o(qc)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two builds (default, and 12-reg/ZERO_R0/no-bypass)
// share one stimulus stream and are checked against an array model.
module tb_regfile_param;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  rna, rnb, rnc, wn0, wn1, busy_rn;
    logic        we0, we1, ar_inc, busy_set;
    logic [15:0] d0, d1;

    logic [15:0] qa1, qb1, qc1, dr1, ar1, busy1;
    logic [15:0] qa2, qb2, qc2, dr2, ar2;
    logic [11:0] busy2;

    always #5 clock = ~clock;

    regfile_param dut1 (
        .clock(clock), .resetn(resetn), .rna(rna), .rnb(rnb), .rnc(rnc),
        .qa(qa1), .qb(qb1), .qc(qc1), .we0(we0), .wn0(wn0), .d0(d0),
        .we1(we1), .wn1(wn1), .d1(d1), .ar_inc(ar_inc), .busy_set(busy_set),
        .busy_rn(busy_rn), .busy(busy1), .DR(dr1), .AR(ar1)
    );

    regfile_param #(
        .NUM_REGS(12), .AR_IDX(10), .DR_IDX(11), .BYPASS(0), .ZERO_R0(1)
    ) dut2 (
        .clock(clock), .resetn(resetn), .rna(rna), .rnb(rnb), .rnc(rnc),
        .qa(qa2), .qb(qb2), .qc(qc2), .we0(we0), .wn0(wn0), .d0(d0),
        .we1(we1), .wn1(wn1), .d1(d1), .ar_inc(ar_inc), .busy_set(busy_set),
        .busy_rn(busy_rn), .busy(busy2), .DR(dr2), .AR(ar2)
    );

    // Model configuration per build: index 0 = dut1, 1 = dut2.
    int NR  [2] = '{16, 12};
    int ZR  [2] = '{0, 1};
    int BP  [2] = '{1, 0};
    int ARI [2] = '{14, 10};
    int DRI [2] = '{15, 11};

    logic [15:0] m_regs [2][16];
    logic [15:0] m_busy [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wr_ok(input int k, input logic we, input int wn);
        return we && (wn < NR[k]) && !(ZR[k] != 0 && wn == 0);
    endfunction

    function automatic logic [15:0] mread(input int k, input int rn);
        if (rn >= NR[k]) return 16'h0;
        if (ZR[k] != 0 && rn == 0) return 16'h0;
        if (BP[k] != 0) begin
            if (wr_ok(k, we0, int'(wn0)) && int'(wn0) == rn) return d0;
            if (wr_ok(k, we1, int'(wn1)) && int'(wn1) == rn) return d1;
        end
        return m_regs[k][rn];
    endfunction

    // Model update: each register takes the highest-priority source aimed at it.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                for (int i = 0; i < 16; i++) m_regs[k][i] = 16'h0;
                m_busy[k] = 16'h0;
            end else begin
                for (int i = 0; i < NR[k]; i++) begin
                    bit hit0, hit1;
                    hit0 = wr_ok(k, we0, int'(wn0)) && int'(wn0) == i;
                    hit1 = wr_ok(k, we1, int'(wn1)) && int'(wn1) == i;
                    if (hit0)                       m_regs[k][i] = d0;
                    else if (hit1)                  m_regs[k][i] = d1;
                    else if (ar_inc && i == ARI[k]) m_regs[k][i] = m_regs[k][i] + 16'd1;
                    if (wr_ok(k, busy_set, int'(busy_rn)) && int'(busy_rn) == i)
                        m_busy[k][i] = 1'b1;
                    else if (hit0 || hit1)
                        m_busy[k][i] = 1'b0;
                end
            end
        end
    end

    // Compare process: inputs change at the falling edge, outputs checked 2 ns later.
    always @(negedge clock) begin
        #2;
        if (chk_en) begin
            chk("qa1", qa1, mread(0, int'(rna)));
            chk("qb1", qb1, mread(0, int'(rnb)));
            chk("qc1", qc1, mread(0, int'(rnc)));
            chk("DR1", dr1, m_regs[0][DRI[0]]);
            chk("AR1", ar1, m_regs[0][ARI[0]]);
            chk("busy1", busy1, m_busy[0]);
            chk("qa2", qa2, mread(1, int'(rna)));
            chk("qb2", qb2, mread(1, int'(rnb)));
            chk("qc2", qc2, mread(1, int'(rnc)));
            chk("DR2", dr2, m_regs[1][DRI[1]]);
            chk("AR2", ar2, m_regs[1][ARI[1]]);
            chk("busy2", {4'h0, busy2}, m_busy[1]);
        end
    end

    task automatic idle();
        resetn = 1'b1;
        we0 = 1'b0; we1 = 1'b0; ar_inc = 1'b0; busy_set = 1'b0;
        rna = 4'd0; rnb = 4'd0; rnc = 4'd0;
        wn0 = 4'd0; wn1 = 4'd0; busy_rn = 4'd0;
        d0 = 16'h0; d1 = 16'h0;
    endtask

    task automatic next_cycle();
        @(negedge clock);
        idle();
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        chk_en = 1'b1;
        #3;
        chk("rst_qa", qa1, 16'h0);
        chk("rst_DR", dr1, 16'h0);
        chk("rst_busy", busy1, 16'h0);

        // Walk port 0 through every index.
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            we0 = 1'b1; wn0 = 4'(i); d0 = 16'h1001 + 16'(i);
            next_cycle();
            rna = 4'(i);
            #3;
            chk("walk_qa", qa1, 16'h1001 + 16'(i));
        end
        chk("walk_DR1", dr1, 16'h1010);
        chk("walk_AR1", ar1, 16'h100F);
        chk("walk_DR2", dr2, 16'h100C);
        chk("walk_AR2", ar2, 16'h100B);

        // Collision on reg 3, then bypass on port B.
        next_cycle();
        we0 = 1'b1; we1 = 1'b1; wn0 = 4'd3; wn1 = 4'd3; d0 = 16'hAAAA; d1 = 16'h5555;
        next_cycle();
        rna = 4'd3;
        #3;
        chk("coll_qa", qa1, 16'hAAAA);
        next_cycle();
        rnb = 4'd3; we1 = 1'b1; wn1 = 4'd3; d1 = 16'h1234;
        #3;
        chk("byp_qb", qb1, 16'h1234);
        chk("nobyp_qb2", qb2, 16'hAAAA);
        next_cycle();
        rnb = 4'd3;
        #3;
        chk("byp_qb_next", qb1, 16'h1234);

        // AR wrap and write-over-increment.
        next_cycle();
        we0 = 1'b1; wn0 = 4'd14; d0 = 16'hFFFE;
        next_cycle();
        ar_inc = 1'b1;
        #3;
        chk("ar_pre", ar1, 16'hFFFE);
        next_cycle();
        ar_inc = 1'b1;
        #3;
        chk("ar_inc1", ar1, 16'hFFFF);
        next_cycle();
        ar_inc = 1'b1;
        #3;
        chk("ar_wrap", ar1, 16'h0000);
        next_cycle();
        ar_inc = 1'b1; we0 = 1'b1; wn0 = 4'd14; d0 = 16'h0040;
        #3;
        chk("ar_inc3", ar1, 16'h0001);
        next_cycle();
        #3;
        chk("ar_wr_wins", ar1, 16'h0040);

        // Scoreboard set / clear / set-wins.
        next_cycle();
        busy_set = 1'b1; busy_rn = 4'd5;
        next_cycle();
        #3;
        chk("busy5_set", 16'(busy1[5]), 16'h1);
        we1 = 1'b1; wn1 = 4'd5; d1 = 16'h0505;
        next_cycle();
        #3;
        chk("busy5_clr", 16'(busy1[5]), 16'h0);
        busy_set = 1'b1; busy_rn = 4'd5; we0 = 1'b1; wn0 = 4'd5; d0 = 16'h7777;
        next_cycle();
        rna = 4'd5;
        #3;
        chk("busy5_win", 16'(busy1[5]), 16'h1);
        chk("reg5_upd", qa1, 16'h7777);

        // Hardwired R0 and out-of-range index.
        next_cycle();
        we0 = 1'b1; wn0 = 4'd0; d0 = 16'hBEEF; busy_set = 1'b1; busy_rn = 4'd0;
        next_cycle();
        rna = 4'd0; we0 = 1'b1; wn0 = 4'd13; d0 = 16'h1313;
        #3;
        chk("r0_zero", qa2, 16'h0);
        chk("r0_busy", 16'(busy2[0]), 16'h0);
        chk("r0_dut1", qa1, 16'hBEEF);
        next_cycle();
        rna = 4'd13;
        #3;
        chk("oor_qa2", qa2, 16'h0);
        chk("oor_qa1", qa1, 16'h1313);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            resetn   = ($urandom_range(0, 39) != 0);
            rna      = 4'($urandom_range(0, 15));
            rnb      = 4'($urandom_range(0, 15));
            rnc      = 4'($urandom_range(0, 15));
            we0      = 1'($urandom_range(0, 1));
            we1      = 1'($urandom_range(0, 1));
            wn0      = 4'($urandom_range(0, 15));
            wn1      = ($urandom_range(0, 3) == 0) ? wn0 : 4'($urandom_range(0, 15));
            d0       = 16'($urandom);
            d1       = 16'($urandom);
            ar_inc   = ($urandom_range(0, 3) == 0);
            busy_set = 1'($urandom_range(0, 1));
            busy_rn  = 4'($urandom_range(0, 15));
        end

        // Mid-run reset discards the same-cycle write.
        next_cycle();
        we0 = 1'b1; wn0 = 4'd2; d0 = 16'h2222; busy_set = 1'b1; busy_rn = 4'd7;
        next_cycle();
        resetn = 1'b0; we0 = 1'b1; wn0 = 4'd2; d0 = 16'h5A5A;
        busy_set = 1'b1; busy_rn = 4'd3; ar_inc = 1'b1;
        next_cycle();
        rna = 4'd2;
        #3;
        chk("mrst_qa", qa1, 16'h0);
        chk("mrst_busy", busy1, 16'h0);
        chk("mrst_DR", dr1, 16'h0);
        chk("mrst_AR", ar1, 16'h0);
        chk("mrst_qa2", qa2, 16'h0);

        next_cycle();
        next_cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the fixed 16x16 tinyGPU register file, with 3 read ports and 1 write port.
- Generalised in data width and register count.
- Adds a second write port with priority, optional same-cycle write-to-read bypass, and optional hardwired-zero R0.
- Adds a post-incrementing AR (address register), a busy scoreboard for in-flight producers, and a synchronous clear.
- Sits between the control unit, ALU and memory interface; DR and AR are exposed as dedicated outputs.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 16, number of registers (2..256, need not be a power of two)
ADDR_W, $clog2(NUM_REGS), register index width
AR_IDX, 14, index of the address register mirrored on AR
DR_IDX, 15, index of the data register mirrored on DR
BYPASS, 1, 1 = reads see same-cycle write data; 0 = reads see stored value
ZERO_R0, 0, 1 = R0 reads 0 and ignores writes

Ports:
clock  input  1  rising-edge clock
resetn  input  1  synchronous active-low reset
rna  input  ADDR_W  read port A index
rnb  input  ADDR_W  read port B index
rnc  input  ADDR_W  read port C index
qa  output  DATA_W  read port A data
qb  output  DATA_W  read port B data
qc  output  DATA_W  read port C data
we0  input  1  write enable, port 0 (high priority)
wn0  input  ADDR_W  write index, port 0
d0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1
wn1  input  ADDR_W  write index, port 1
d1  input  DATA_W  write data, port 1
ar_inc  input  1  post-increment AR this cycle
busy_set  input  1  mark register busy_rn as pending
busy_rn  input  ADDR_W  index marked by busy_set
busy  output  NUM_REGS  per-register pending bits
DR  output  DATA_W  contents of register DR_IDX
AR  output  DATA_W  contents of register AR_IDX

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-low, resetn.
- Reset: resetn=0 at a rising edge clears all registers and busy bits to 0. After reset, qa/qb/qc/DR/AR = 0 and busy = 0. Reset overrides every same-cycle write, increment and busy_set. Reset mid-operation discards pending writes.
- Reads: combinational, zero cycles of latency.
  - Index >= NUM_REGS returns 0.
  - ZERO_R0=1: index 0 returns 0.
- Writes: take effect at the rising edge when weX=1 and the index is valid. Visible on q* and DR/AR in the next cycle.
- Write collision: we0 and we1 both high with wn0==wn1 -> d0 stored, d1 dropped.
- Ignored writes: an index >= NUM_REGS is ignored; with ZERO_R0=1, a write to R0 is ignored.
- Bypass (BYPASS=1): when a read index equals an enabled, valid write index in the same cycle, the read returns the write data. If both write ports match, port 0 wins. The bypass applies to qa/qb/qc only; DR and AR always show stored values.
- AR increment: ar_inc=1 sets reg[AR_IDX] <= reg[AR_IDX]+1 mod 2^DATA_W, so 0xFFFF wraps to 0x0000 for DATA_W=16. Any same-cycle write to AR_IDX takes precedence and the increment is dropped.
- Scoreboard:
  - busy_set=1 sets busy[busy_rn] at the edge.
  - Any accepted write to index i clears busy[i].
  - If set and clear hit the same index in the same cycle, set wins (the new producer is pending).
  - busy_set with an invalid index, or with index 0 when ZERO_R0=1, is ignored.
  - busy is advisory only; it does not block writes.
- No handshake: every accepted operation completes in one cycle, with no stalls.

Decomposition:
- tinygpu_pkg holds shared constants: default DATA_W, NUM_REGS, AR_IDX, DR_IDX, and the opcode-independent register-index names, so the control unit and testbenches share them.
- One sub-module, regfile_read_port: index decode, range check, R0 zeroing and bypass mux.
- regfile_read_port is instantiated three times (A, B, C).
- Storage, write arbitration, AR increment and the scoreboard stay in the top module.

Test Plan:
- Reset, then walk the write ports: we0 writes 0x1001+i to reg i for i=0..15, reading rna=i each following cycle -> qa==0x1001+i; DR==0x1010; AR==0x100F.
- Write collision: we0=we1=1, wn0=wn1=3, d0=0xAAAA, d1=0x5555 -> reg3==0xAAAA. Then BYPASS=1 with rnb=3, we1=1, wn1=3, d1=0x1234 -> qb==0x1234 in the same cycle, and qb==0x1234 next cycle.
- AR wrap: AR preloaded to 0xFFFE, ar_inc held 3 cycles -> 0xFFFF, 0x0000, 0x0001. ar_inc with we0 to AR_IDX (d0=0x0040) -> AR==0x0040.
- Scoreboard: busy_set rn=5 -> busy[5]=1. we1 to reg 5 -> busy[5]=0. busy_set rn=5 plus we0 to reg 5 in the same cycle -> busy[5]=1, reg5 updated.
- ZERO_R0=1 build: write 0xBEEF to R0 -> qa(rna=0)==0 and busy[0] never sets. With NUM_REGS=12, a write to index 13 is ignored and a read of 13 returns 0.
- Mid-run reset: nonzero registers, busy bits set, and we0 asserted with resetn=0 -> all outputs 0 next cycle and the write is not stored.
